// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
// text_pkg : shared grid geometry, control codes and FSM states for the text
//            terminal path (cursor controller and framebuffer read side)
// Rev 1.0
// ============================================================================
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cursor_addr.sv
`default_nettype none
// ============================================================================
// cursor_addr : combinational row/col to linear framebuffer cell address
// Rev 1.0
// ============================================================================
module cursor_addr #(
  parameter int COLS   = text_pkg::COLS,
  parameter int ADDR_W = text_pkg::ADDR_W
) (
  input  logic [6:0]        col,
  input  logic [4:0]        row,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] row_w;
  logic [ADDR_W-1:0] col_w;

  assign row_w = ADDR_W'(row);
  assign col_w = ADDR_W'(col);

  generate
    if (COLS == 80) begin : g_shift
      // 80 = 64 + 16, so two shifts and an add replace the multiplier
      assign addr = (row_w << 6) + (row_w << 4) + col_w;
    end else begin : g_mul
      assign addr = row_w * ADDR_W'(COLS) + col_w;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/text_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// text_cursor_ctrl : byte-stream terminal controller driving framebuffer writes
// Rev 1.0
// ============================================================================
module text_cursor_ctrl #(
  parameter int COLS   = text_pkg::COLS,
  parameter int ROWS   = text_pkg::ROWS,
  parameter int ADDR_W = text_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_char,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy,
  output logic              overrun
);

  import text_pkg::*;

  localparam int          CNT_W    = ADDR_W + 1;
  localparam int          TOTAL    = COLS * ROWS;
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

  state_t            state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic              pend_full_q, pend_full_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic [CNT_W-1:0]  clr_q, clr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_char_q, wr_char_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              take;
  logic [7:0]        byte_in;
  logic [6:0]        tgt_col;
  logic [4:0]        next_row;
  logic [ADDR_W-1:0] tgt_addr;

  // The pending byte is older than anything on rx_data, so it always goes first
  assign take     = (state_q == ST_IDLE) && (pend_full_q || rx_valid);
  assign byte_in  = pend_full_q ? pend_data_q : rx_data;
  assign tgt_col  = (byte_in == CHAR_BS) ? col_q - 7'd1 : col_q;
  assign next_row = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

  cursor_addr #(
    .COLS   (COLS),
    .ADDR_W (ADDR_W)
  ) u_cursor_addr (
    .col  (tgt_col),
    .row  (row_q),
    .addr (tgt_addr)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    clr_d       = clr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_char_d   = wr_char_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (pend_full_q) begin
          pend_full_d = rx_valid;
          if (rx_valid) pend_data_d = rx_data;
        end
        if (take) begin
          if (byte_in inside {[8'h20:8'h7E]}) begin
            wr_en_d   = 1'b1;
            wr_addr_d = tgt_addr;
            wr_char_d = byte_in;
            if (col_q == LAST_COL) begin
              col_d = 7'd0;
              row_d = next_row;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else if (byte_in == CHAR_CR) begin
            col_d = 7'd0;
          end else if (byte_in == CHAR_LF) begin
            col_d = 7'd0;
            row_d = next_row;
          end else if (byte_in == CHAR_BS) begin
            if (col_q != 7'd0) begin
              col_d     = tgt_col;
              wr_en_d   = 1'b1;
              wr_addr_d = tgt_addr;
              wr_char_d = CHAR_SPACE;
            end
          end else if (byte_in == CHAR_FF) begin
            // Cell 0 is written on entry so busy and wr_en rise together
            state_d   = ST_CLEAR;
            col_d     = 7'd0;
            row_d     = 5'd0;
            busy_d    = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_char_d = CHAR_SPACE;
            clr_d     = CNT_W'(1);
          end
        end
      end

      ST_CLEAR: begin
        if (rx_valid) begin
          if (pend_full_q) begin
            overrun_d = 1'b1;
          end else begin
            pend_full_d = 1'b1;
            pend_data_d = rx_data;
          end
        end
        if (clr_q == CNT_W'(TOTAL)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_q[ADDR_W-1:0];
          wr_char_d = CHAR_SPACE;
          clr_d     = clr_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= 7'd0;
      row_q       <= 5'd0;
      pend_full_q <= 1'b0;
      pend_data_q <= 8'h00;
      clr_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_char_q   <= 8'h00;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pend_full_q <= pend_full_d;
      pend_data_q <= pend_data_d;
      clr_q       <= clr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_char_q   <= wr_char_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_char    = wr_char_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire
